// File: rtl/lca_pkg.sv
// Shared core package: word width, reset PC, fetch pair bundle.
// Consumed by fetch_stage and the decode stage.
package lca_pkg;

    localparam int   XLEN         = 16;
    localparam int   MAX_OUTST    = 2;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t ir;
    } fetch_pair_t;

    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO with flush; head is visible on rdata_o.
// Push while full is accepted only together with a pop.
module fetch_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok, pop_ok;

    always_comb begin
        pop_ok  = pop_i && (cnt_q != 2'd0);
        push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            rd_d  = 1'b0;
            wr_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = wdata_i;
                wr_d        = ~wr_q;
            end
            if (pop_ok) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, 2-entry buffer, redirect squash.
// FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_stage
    import lca_pkg::*;
#(
    parameter pc_t RESET_PC  = RESET_PC_DEF,
    parameter int  MAX_OUTST = lca_pkg::MAX_OUTST
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   imem_req,
    output pc_t    imem_addr,
    input  logic   imem_gnt,
    input  logic   imem_rvalid,
    input  instr_t imem_rdata,
    input  logic   stall,
    input  logic   redirect,
    input  pc_t    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall_cycles,
`endif
    output pc_t    toPipe1PC,
    output instr_t toPipe1IR,
    output logic   toPipe1Valid
);

    pc_t         pc_q, pc_d;
    logic [1:0]  discard_q, discard_d;
    fetch_pair_t p1_q, p1_d;
    logic        p1_valid_q, p1_valid_d;

    logic [1:0]  pcq_cnt, buf_cnt;
    logic        pcq_empty, buf_empty;
    pc_t         pcq_head;
    fetch_pair_t buf_head;
    fetch_pair_t rsp_pair;

    logic [2:0]  outst;
    logic        fire, rsp, keep, p1_free, p1_load;
    logic        buf_push, buf_pop;

    fetch_fifo2 #(.W(XLEN)) u_pcq (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (fire),
        .pop_i   (rsp),
        .wdata_i (pc_q),
        .rdata_o (pcq_head),
        .count_o (pcq_cnt),
        .empty_o (pcq_empty)
    );

    fetch_fifo2 #(.W(2 * XLEN)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .wdata_i (rsp_pair),
        .rdata_o (buf_head),
        .count_o (buf_cnt),
        .empty_o (buf_empty)
    );

    always_comb begin
        outst    = {1'b0, pcq_cnt} + {1'b0, buf_cnt};
        imem_req = !redirect && (outst < 3'(MAX_OUTST));
        fire     = imem_req && imem_gnt;
        rsp      = imem_rvalid && !pcq_empty;
        keep     = rsp && !redirect && (discard_q == 2'd0);
        rsp_pair = '{pc: pcq_head, ir: imem_rdata};
        p1_free  = !p1_valid_q || !stall;

        pc_d       = pc_q;
        discard_d  = discard_q;
        p1_d       = p1_q;
        p1_valid_d = p1_valid_q;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        p1_load    = 1'b0;

        if (redirect) begin
            // Everything still in flight after this cycle is wrong-path.
            pc_d       = redirect_pc;
            discard_d  = pcq_cnt - {1'b0, rsp};
            p1_valid_d = 1'b0;
        end else begin
            if (fire) begin
                pc_d = pc_inc(pc_q);
            end
            if (rsp && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end
            if (p1_free) begin
                if (!buf_empty) begin
                    p1_d       = buf_head;
                    p1_valid_d = 1'b1;
                    p1_load    = 1'b1;
                    buf_pop    = 1'b1;
                    buf_push   = keep;
                end else if (keep) begin
                    p1_d       = rsp_pair;
                    p1_valid_d = 1'b1;
                    p1_load    = 1'b1;
                end else begin
                    p1_valid_d = 1'b0;
                end
            end else begin
                buf_push = keep;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            discard_q  <= 2'd0;
            p1_q       <= '0;
            p1_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            p1_q       <= p1_d;
            p1_valid_q <= p1_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_q, stall_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q   <= 16'd0;
            stall_cyc_q <= 16'd0;
        end else begin
            if (p1_load) begin
                fetched_q <= fetched_q + 16'd1;
            end
            if (stall && p1_valid_q) begin
                stall_cyc_q <= stall_cyc_q + 16'd1;
            end
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stall_cyc_q;
`else
    logic unused_load;
    assign unused_load = p1_load;
`endif

`ifndef SYNTHESIS
    a_rvalid_orphan: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && pcq_empty)
    );
`endif

    assign imem_addr    = pc_q;
    assign toPipe1PC    = p1_q.pc;
    assign toPipe1IR    = p1_q.ir;
    assign toPipe1Valid = p1_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall, redirect, gnt backpressure.
// A second instance covers RESET_PC wrap at 16'hFFFF.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_gnt, stall, redirect;
    logic [15:0] redirect_pc;

    logic        imem_req, imem_rvalid, v1;
    logic [15:0] imem_addr, imem_rdata, pc1, ir1;

    logic        req_b, rvalid_b, v_b;
    logic [15:0] addr_b, rdata_b, pc_b, ir_b;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] pf_a, ps_a, pf_b, ps_b;
`endif

    int checks = 0;
    int failures = 0;
    int lat;
    int mcyc;
    logic [15:0] q_addr[$];
    int q_due[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched      (pf_a),
        .perf_stall_cycles (ps_a),
`endif
        .toPipe1PC    (pc1),
        .toPipe1IR    (ir1),
        .toPipe1Valid (v1)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (req_b),
        .imem_addr    (addr_b),
        .imem_gnt     (1'b1),
        .imem_rvalid  (rvalid_b),
        .imem_rdata   (rdata_b),
        .stall        (1'b0),
        .redirect     (1'b0),
        .redirect_pc  (16'h0000),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched      (pf_b),
        .perf_stall_cycles (ps_b),
`endif
        .toPipe1PC    (pc_b),
        .toPipe1IR    (ir_b),
        .toPipe1Valid (v_b)
    );

    // In-order memory with programmable latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 16'h0;
            q_addr.delete();
            q_due.delete();
            mcyc <= 0;
        end else begin
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(mcyc + lat);
            end
            if (q_due.size() > 0 && q_due[0] == mcyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= q_addr[0] ^ 16'hA5A5;
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
            mcyc <= mcyc + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_b <= 1'b0;
            rdata_b  <= 16'h0;
        end else begin
            rvalid_b <= req_b;
            rdata_b  <= addr_b ^ 16'hA5A5;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] e, eb;
        rst_n = 1'b0;
        imem_gnt = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        lat = 1;
        repeat (2) step();
        checks++;
        if (v1 !== 1'b0 || pc1 !== 16'h0 || ir1 !== 16'h0) begin
            failures++;
            $display("FAIL reset_pipe1: got v=%b pc=%h ir=%h want 0/0000/0000", v1, pc1, ir1);
        end
        checks++;
        if (imem_addr !== 16'h0000 || addr_b !== 16'hFFFE || v_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_pc: got a=%h b=%h vb=%b want 0000/fffe/0", imem_addr, addr_b, v_b);
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_req: got %b want 1", imem_req);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (v1 !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_c1: got v=%b want 0", v1);
                end
            end else begin
                e  = 16'(k - 2);
                eb = 16'hFFFE + 16'(k - 2);
                checks++;
                if (v1 !== 1'b1 || pc1 !== e || ir1 !== (e ^ 16'hA5A5)) begin
                    failures++;
                    $display("FAIL stream_c%0d: got v=%b pc=%h ir=%h want 1/%h/%h",
                             k, v1, pc1, ir1, e, e ^ 16'hA5A5);
                end
                checks++;
                if (v_b !== 1'b1 || pc_b !== eb || ir_b !== (eb ^ 16'hA5A5)) begin
                    failures++;
                    $display("FAIL wrap_c%0d: got v=%b pc=%h ir=%h want 1/%h/%h",
                             k, v_b, pc_b, ir_b, eb, eb ^ 16'hA5A5);
                end
            end
`ifdef FETCH_PERF_CNT_EN
            if (k == 4) begin
                checks++;
                if (pf_b !== 16'd3) begin
                    failures++;
                    $display("FAIL perf_fetched: got %0d want 3", pf_b);
                end
            end
`endif
        end
    endtask

    // Pipe1 shows PC 6 on entry.
    task automatic test_stall();
        logic [15:0] e;
        stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (v1 !== 1'b1 || pc1 !== 16'h0006 || ir1 !== (16'h0006 ^ 16'hA5A5)) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h want 1/0006", i, v1, pc1);
            end
            if (i >= 2) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_req%0d: got %b want 0", i, imem_req);
                end
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (ps_a !== 16'd5) begin
            failures++;
            $display("FAIL perf_stall: got %0d want 5", ps_a);
        end
`endif
        stall = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            e = 16'h0006 + 16'(j);
            checks++;
            if (v1 !== 1'b1 || pc1 !== e || ir1 !== (e ^ 16'hA5A5)) begin
                failures++;
                $display("FAIL drain%0d: got v=%b pc=%h want 1/%h", j, v1, pc1, e);
            end
        end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        lat = 2;
        for (int i = 0; i < 12; i++) begin
            step();
            if (q_addr.size() + int'(imem_rvalid) == 2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL redir_setup: got no 2-outstanding window want one");
        end
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        lat = 1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL redir_noreq: got %b want 0", imem_req);
        end
        step();
        redirect = 1'b0;
        checks++;
        if (v1 !== 1'b0) begin
            failures++;
            $display("FAIL redir_inval: got v=%b want 0", v1);
        end
        step();
        checks++;
        if (v1 !== 1'b0) begin
            failures++;
            $display("FAIL redir_drop: got v=%b pc=%h want 0", v1, pc1);
        end
        step();
        checks++;
        if (v1 !== 1'b1 || pc1 !== 16'h0040 || ir1 !== (16'h0040 ^ 16'hA5A5)) begin
            failures++;
            $display("FAIL redir_target: got v=%b pc=%h ir=%h want 1/0040/%h",
                     v1, pc1, ir1, 16'h0040 ^ 16'hA5A5);
        end
    endtask

    task automatic test_redirect_stall();
        bit seen = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || v1 !== 1'b1) begin
            failures++;
            $display("FAIL rs_setup: got rvalid=%b v=%b want 1/1", seen, v1);
        end
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        checks++;
        if (v1 !== 1'b0) begin
            failures++;
            $display("FAIL rs_inval: got v=%b want 0", v1);
        end
        step();
        checks++;
        if (v1 !== 1'b0) begin
            failures++;
            $display("FAIL rs_drop: got v=%b pc=%h want 0", v1, pc1);
        end
        step();
        checks++;
        if (v1 !== 1'b1 || pc1 !== 16'h0100) begin
            failures++;
            $display("FAIL rs_target: got v=%b pc=%h want 1/0100", v1, pc1);
        end
    endtask

    // Pipe1 shows 0100, 0101 returning, 0102 being requested.
    task automatic test_gnt_low();
        logic [15:0] want_pc [1:7];
        logic        want_v [1:7];
        want_v[1] = 1'b1; want_pc[1] = 16'h0101;
        want_v[2] = 1'b0; want_pc[2] = 16'h0000;
        want_v[3] = 1'b0; want_pc[3] = 16'h0000;
        want_v[4] = 1'b0; want_pc[4] = 16'h0000;
        want_v[5] = 1'b1; want_pc[5] = 16'h0102;
        want_v[6] = 1'b1; want_pc[6] = 16'h0103;
        want_v[7] = 1'b1; want_pc[7] = 16'h0104;
        imem_gnt = 1'b0;
        checks++;
        if (imem_addr !== 16'h0102) begin
            failures++;
            $display("FAIL gnt_addr0: got %h want 0102", imem_addr);
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i <= 3) begin
                checks++;
                if (imem_addr !== 16'h0102 || imem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL gnt_hold%0d: got a=%h req=%b want 0102/1",
                             i, imem_addr, imem_req);
                end
            end
            if (i == 3) begin
                imem_gnt = 1'b1;
            end
            checks++;
            if (v1 !== want_v[i] || (want_v[i] && pc1 !== want_pc[i])) begin
                failures++;
                $display("FAIL gnt_seq%0d: got v=%b pc=%h want %b/%h",
                         i, v1, pc1, want_v[i], want_pc[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_gnt_low();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
